rsa_modexp: RTL

RSA_MODEXP -- requirements
Module: rsa_modexp

---
 rtl/rsa_modexp.sv | 133 +++++++++++++
 1 files changed

// File: rtl/rsa_modexp.sv
// Modular exponentiation (LSB-first square-and-multiply) over a bit-serial interleaved modular multiplier.
// Optional RSA_CONST_TIME_EN: run MUL for every exponent bit so latency is independent of the exponent.
module rsa_modexp #(
   parameter int WIDTH     = 16,
   parameter int EXP_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     message,
   input  logic [EXP_WIDTH-1:0] exponent,
   input  logic [WIDTH-1:0]     modulus,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [WIDTH-1:0]     result
);

   localparam int CW = $clog2(WIDTH);
   localparam int EW = $clog2(EXP_WIDTH + 1);
`ifdef RSA_CONST_TIME_EN
   localparam bit CT = 1'b1;
`else
   localparam bit CT = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, REDUCE, MUL, SQR, FIN} state_t;

   state_t               r_state, w_next;
   logic [WIDTH:0]       r_acc;
   logic [WIDTH-1:0]     r_n, r_a, r_base, r_res, r_result;
   logic [EXP_WIDTH-1:0] r_exp;
   logic [CW-1:0]        r_cnt;
   logic [EW-1:0]        r_ebit;
   logic                 r_zero;

   logic [WIDTH:0]       w_n, w_b, w_dbl, w_d1, w_sum, w_d2;
   logic [WIDTH-1:0]     w_prod;
   logic [EXP_WIDTH-1:0] w_exp_nxt;
   logic                 w_last;

   // One multiplier step: acc = 2*acc mod n, then acc += (a_bit ? b : 0) mod n.
   // REDUCE scans message against b=1, so operands stay below n even when message >= n.
   always_comb begin
      w_n       = {1'b0, r_n};
      w_b       = (r_state == REDUCE) ? {{WIDTH{1'b0}}, 1'b1} : {1'b0, r_base};
      w_dbl     = r_acc << 1;
      w_d1      = (w_dbl >= w_n) ? w_dbl - w_n : w_dbl;
      w_sum     = w_d1 + (r_a[WIDTH-1] ? w_b : '0);
      w_d2      = (w_sum >= w_n) ? w_sum - w_n : w_sum;
      w_prod    = WIDTH'(w_d2);
      w_last    = (r_cnt == CW'(WIDTH - 1));
      w_exp_nxt = r_exp >> 1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (start) w_next = (modulus == '0) ? FIN : REDUCE;
         REDUCE:  if (w_last) w_next = (CT || r_exp[0]) ? MUL : SQR;
         MUL:     if (w_last) w_next = SQR;
         SQR:     if (w_last) w_next = (r_ebit == EW'(EXP_WIDTH - 1)) ? FIN :
                                       ((CT || w_exp_nxt[0]) ? MUL : SQR);
         FIN:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_n      <= '0;
         r_a      <= '0;
         r_base   <= '0;
         r_res    <= '0;
         r_result <= '0;
         r_exp    <= '0;
         r_cnt    <= '0;
         r_ebit   <= '0;
         r_zero   <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: if (start) begin
               r_n    <= modulus;
               r_exp  <= exponent;
               r_a    <= message;
               r_acc  <= '0;
               r_cnt  <= '0;
               r_ebit <= '0;
               r_res  <= (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
               r_zero <= (modulus == '0);
               if (modulus == '0) r_result <= '0;
            end
            REDUCE, MUL, SQR: begin
               if (!w_last) begin
                  r_acc <= w_d2;
                  r_a   <= r_a << 1;
                  r_cnt <= r_cnt + 1'b1;
               end else begin
                  r_acc <= '0;
                  r_cnt <= '0;
                  if (r_state == REDUCE) r_base <= w_prod;
                  // In the constant-time build the product of a zero bit is dropped here.
                  if (r_state == MUL && r_exp[0]) r_res <= w_prod;
                  if (r_state == SQR) begin
                     r_base <= w_prod;
                     r_exp  <= w_exp_nxt;
                     r_ebit <= r_ebit + 1'b1;
                  end
                  unique case (w_next)
                     MUL:     r_a <= r_res;
                     SQR:     r_a <= (r_state == MUL) ? r_base : w_prod;
                     FIN:     r_result <= r_res;
                     default: ;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

   assign done   = (r_state == FIN);
   assign error  = done && r_zero;
   assign busy   = (r_state != IDLE) && !r_zero;
   assign result = r_result;

endmodule
